// File: rtl/led_trail_fader_pkg.sv
// Shared constants for the LED trail fader: pin polarity and the board and
// simulation defaults for channel count, PWM width and decay rate.
package led_pkg;

  localparam int DEF_N_LEDS = 6;

  // The board pins sink current, so a driven 0 lights the LED.
  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  localparam int PWM_BITS_BOARD    = 8;
  localparam int DECAY_DIV_BOARD   = 1000000;
  localparam int DECAY_SHIFT_BOARD = 3;

  localparam int PWM_BITS_SIM      = 8;
  localparam int DECAY_DIV_SIM     = 4;
  localparam int DECAY_SHIFT_SIM   = 3;

  // The prescaler needs at least one bit even when it never counts.
  function automatic int pre_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_trail_fader_if.sv
// Runner-to-pin connection of the trail fader: active-low pattern in,
// active-low pin drive out.
interface led_trail_fader_if
  import led_pkg::*;
#(
  parameter int N_LEDS = DEF_N_LEDS
);

  logic [N_LEDS-1:0] pattern_n;
  logic [N_LEDS-1:0] leds_n;

  modport master (output pattern_n, input leds_n);
  modport slave  (input pattern_n, output leds_n);

endinterface

// File: rtl/led_trail_fader_channel.sv
// One fading LED channel: brightness register with geometric decay and a
// registered PWM comparator driving one active-low pin.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_BOARD,
  parameter int DECAY_SHIFT = DECAY_SHIFT_BOARD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lit,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm,
  output logic                led_n
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] b;
  logic [PWM_BITS-1:0] b_next;
  logic [PWM_BITS-1:0] step;

  // The step is at most b/2 + 1 <= b for b != 0, so the subtraction cannot wrap.
  always_comb begin
    // NOTE: defaults first so every path assigns b_next and no latch is inferred.
    step   = (b >> DECAY_SHIFT) + PWM_BITS'(1);
    b_next = b;
    if (lit) begin
      b_next = MAX;
    end else if (tick && (b != '0)) begin
      b_next = b - step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b     <= '0;
      led_n <= LED_OFF;
    end else begin
      // NOTE: non-blocking so the comparator sees the pre-edge brightness.
      b     <= b_next;
      led_n <= ((b == MAX) || (b > pwm)) ? LED_ON : LED_OFF;
    end
  end

endmodule

// File: rtl/led_trail_fader.sv
// Output stage between the six-LED runner and the pins: registers the runner
// pattern and fans it out to per-LED fading PWM channels.
module led_trail_fader
  import led_pkg::*;
#(
  parameter int N_LEDS      = DEF_N_LEDS,
  parameter int PWM_BITS    = PWM_BITS_BOARD,
  parameter int DECAY_DIV   = DECAY_DIV_BOARD,
  parameter int DECAY_SHIFT = DECAY_SHIFT_BOARD
) (
  input  logic              clk,
  input  logic              reset,
  led_trail_fader_if.slave  bus
);

  localparam int                PRE_W    = pre_width(DECAY_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]   pat_q;
  logic [PRE_W-1:0]    pre;
  logic [PWM_BITS-1:0] pwm;
  logic                tick;
  wire  [N_LEDS-1:0]   leds_w;

  assign tick = (pre == PRE_LAST);

  // Prescaler and PWM counter free-run; they never stall on pattern activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= '1;
      pre   <= '0;
      pwm   <= '0;
    end else begin
      pat_q <= bus.pattern_n;
      pre   <= tick ? '0 : pre + PRE_W'(1);
      pwm   <= pwm + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS    (PWM_BITS),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .lit   (pat_q[i] == LED_ON),
      .tick  (tick),
      .pwm   (pwm),
      .led_n (leds_w[i])
    );
  end

  assign bus.leds_n = leds_w;

endmodule
